// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// the default operand width and the bit-counter width helper.
package serial_pkg;

   // FSM encoding shared by the serial arithmetic blocks.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } serial_state_e;

   // Default operand / result width.
   localparam int SERIAL_WIDTH_DEFAULT = 32;

   // Width of a counter that indexes bits 0 .. w-1.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   localparam int SERIAL_CNT_W_DEFAULT = cnt_width(SERIAL_WIDTH_DEFAULT);

endpackage : serial_pkg

// File: rtl/one_bit_subtractor.sv
// Combinational full-subtractor cell: d = a - b - bin, with borrow out.
module one_bit_subtractor (
   input  logic bin,
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   // Difference bit and borrow generation for one bit position.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule : one_bit_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first, borrow rippled through a single one_bit_subtractor cell.
// Optional signed-overflow flag is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero,
`ifdef SERIAL_SUB_OVF_EN
   output logic             negative,
   output logic             overflow
`else
   output logic             negative
`endif
);

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   serial_state_e     state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   // Holds the low WIDTH-1 result bits; the final bit goes straight to diff.
   logic [WIDTH-2:0]  partial_q, partial_d;
   logic              borrow_q, borrow_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              borrow_out_q, borrow_out_d;
   logic              zero_q, zero_d;
   logic              negative_q, negative_d;
`ifdef SERIAL_SUB_OVF_EN
   logic              a_msb_q, a_msb_d;
   logic              b_msb_q, b_msb_d;
   logic              overflow_q, overflow_d;
`endif

   logic              cell_d;
   logic              cell_bout;
   logic [WIDTH-1:0]  final_diff;

   one_bit_subtractor u_cell (
      .bin  (borrow_q),
      .a    (a_q[0]),
      .b    (b_q[0]),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Result as it will look once the current (last) bit is shifted in.
   assign final_diff = {cell_d, partial_q};

   // Next-state, datapath shifting and result capture on the final bit.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves
      // one unassigned and no latch is inferred.
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      partial_d    = partial_q;
      borrow_d     = borrow_q;
      cnt_d        = cnt_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      zero_d       = zero_q;
      negative_d   = negative_q;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d      = a_msb_q;
      b_msb_d      = b_msb_q;
      overflow_d   = overflow_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
`endif
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end

         ST_RUN: begin
            a_d       = a_q >> 1;
            b_d       = b_q >> 1;
            partial_d = final_diff[WIDTH-1:1];
            borrow_d  = cell_bout;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d      = ST_DONE;
               diff_d       = final_diff;
               borrow_out_d = cell_bout;
               zero_d       = (final_diff == '0);
               negative_d   = cell_d;
`ifdef SERIAL_SUB_OVF_EN
               overflow_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath and result registers; reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments in clocked logic so every flop
         // samples pre-edge values regardless of statement order.
         state_q      <= ST_IDLE;
         // NOTE: the operand shift registers are reset as well; they are few
         // flops and this keeps X out of the borrow chain after power-up.
         a_q          <= '0;
         b_q          <= '0;
         partial_q    <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         zero_q       <= 1'b0;
         negative_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         overflow_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         partial_q    <= partial_d;
         borrow_q     <= borrow_d;
         cnt_q        <= cnt_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         zero_q       <= zero_d;
         negative_q   <= negative_d;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q      <= a_msb_d;
         b_msb_q      <= b_msb_d;
         overflow_q   <= overflow_d;
`endif
      end
   end

   // Handshake decodes straight from the state register (no start bypass).
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign zero       = zero_q;
   assign negative   = negative_q;
`ifdef SERIAL_SUB_OVF_EN
   assign overflow   = overflow_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH = 32).
module tb_serial_subtractor;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         zero;
   logic         negative;
`ifdef SERIAL_SUB_OVF_EN
   logic         overflow;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .zero       (zero),
`ifdef SERIAL_SUB_OVF_EN
      .negative   (negative),
      .overflow   (overflow)
`else
      .negative   (negative)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Start an operation from the current low phase, optionally pulse a
   // second (to-be-ignored) start at RUN cycle pulse_at, and wait for done.
   // Returns at the negedge where done is first seen high.
   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input int pulse_at,
                         input logic [W-1:0] p_a, input logic [W-1:0] p_b);
      int lat;
      int gaps;
      start = 1'b1;
      a     = op_a;
      b     = op_b;
      @(negedge clk);
      start = 1'b0;
      a     = '0;
      b     = '0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("done_low_in_run", {31'd0, done}, 32'd0);
      lat  = 0;
      gaps = 0;
      while (!done && lat < W + 8) begin
         if (!busy) gaps++;
         if (lat == pulse_at) begin
            start = 1'b1;
            a     = p_a;
            b     = p_b;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("latency", lat, W);
      check("busy_continuous", gaps, 0);
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_result(input logic [W-1:0] e_diff, input logic e_bo,
                               input logic e_z, input logic e_n,
                               input logic e_ovf);
      check("diff", diff, e_diff);
      check("borrow_out", {31'd0, borrow_out}, {31'd0, e_bo});
      check("zero", {31'd0, zero}, {31'd0, e_z});
      check("negative", {31'd0, negative}, {31'd0, e_n});
`ifdef SERIAL_SUB_OVF_EN
      check("overflow", {31'd0, overflow}, {31'd0, e_ovf});
`else
      if (e_ovf === 1'bx) checks = checks;
`endif
   endtask

   // Advance one cycle after done and confirm the pulse ended and results held.
   task automatic check_pulse_end(input logic [W-1:0] e_diff);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_not_busy", {31'd0, busy}, 32'd0);
      check("diff_held", diff, e_diff);
   endtask

   initial begin
      int done_seen;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_diff", diff, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 5 - 0
      run_op(32'd5, 32'd0, -1, '0, '0);
      check_result(32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      check_pulse_end(32'd5);

      // 3 - 5: unsigned borrow, negative result
      run_op(32'd3, 32'd5, -1, '0, '0);
      check_result(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
      check_pulse_end(32'hFFFF_FFFE);

      // 7 - 7: zero
      run_op(32'd7, 32'd7, -1, '0, '0);
      check_result(32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_pulse_end(32'd0);

      // most-negative minus one: signed overflow
      run_op(32'h8000_0000, 32'd1, -1, '0, '0);
      check_result(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);

      // back-to-back from DONE, with an ignored start pulse at RUN cycle 5
      run_op(32'd10, 32'd4, 5, 32'd1, 32'd2);
      check_result(32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      check_pulse_end(32'd6);

      // 0 - 1
      run_op(32'd0, 32'd1, -1, '0, '0);
      check_result(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
      check_pulse_end(32'hFFFF_FFFF);

      // max positive minus -1: overflow, unsigned borrow
      run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, -1, '0, '0);
      check_result(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
      check_pulse_end(32'h8000_0000);

      // abort 9 - 1 mid-run with asynchronous reset
      start = 1'b1;
      a     = 32'd9;
      b     = 32'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before_rst", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_diff", diff, 32'd0);
      check("abort_borrow", {31'd0, borrow_out}, 32'd0);
      check("abort_zero", {31'd0, zero}, 32'd0);
      check("abort_negative", {31'd0, negative}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("abort_overflow", {31'd0, overflow}, 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("no_done_after_abort", done_seen, 0);

      // fresh operation after the abort
      run_op(32'd9, 32'd1, -1, '0, '0);
      check_result(32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      check_pulse_end(32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_subtractor
